mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares one memory bus between the instruction-fetch port (if_stage) and the data port (mem_stage) of the RV32I core.
//  Allows one outstanding bus transaction. Data has priority; a streak counter guarantees fetch forward progress.
//  Drives stall flags to hazard_unit. Discards responses to fetches that branch_unit flushed.
// PARAMETERS
//  ADDR_W      32  address width, all ports
//  DATA_W      32  data width, all ports
//  STREAK_MAX  4   max consecutive data grants while if_req is pending; the next grant goes to fetch
// PORTS
//  clk        in   1         clock; all logic on rising edge
//  rst        in   1         synchronous, active-low reset
//  if_req     in   1         fetch request; held with if_addr stable until if_rvalid or if_flush
//  if_addr    in   ADDR_W    fetch address
//  if_flush   in   1         redirect; abandon any pending or outstanding fetch
//  if_rvalid  out  1         fetch data valid (1 cycle)
//  if_rdata   out  DATA_W    fetched instruction
//  if_stall   out  1         if_req & ~if_rvalid
//  dm_req     in   1         data request; dm_* held stable until dm_rvalid
//  dm_we      in   1         1 = store
//  dm_be      in   DATA_W/8  byte enables
//  dm_addr    in   ADDR_W    data address
//  dm_wdata   in   DATA_W    store data
//  dm_rvalid  out  1         load data / store ack (1 cycle)
//  dm_rdata   out  DATA_W    load data
//  dm_err     out  1         bus_err qualified by dm_rvalid
//  dm_stall   out  1         dm_req & ~dm_rvalid
//  bus_req    out  1         registered; held with fields stable until bus_gnt
//  bus_we     out  1         registered
//  bus_be     out  DATA_W/8  registered
//  bus_addr   out  ADDR_W    registered
//  bus_wdata  out  DATA_W    registered
//  bus_gnt    in   1         request accepted this cycle when bus_req=1
//  bus_rvalid in   1         response for the accepted request; any later cycle
//  bus_rdata  in   DATA_W    response data
//  bus_err    in   1         response error
// BEHAVIOUR
//  Reset (rst=0 at edge): state=IDLE; bus_* regs=0; streak=0; drop=0; owner=DM.
//   if_rvalid, dm_rvalid, if_rdata and dm_rdata read 0 (gated by state).
//  FSM:
//   IDLE: arbitrate on the sampled requests. Latch the winner's fields into the bus regs, set bus_req<=1, go to REQ.
//    bus_req rises one cycle after the request is seen.
//    Winner: DM if dm_req and not (if_req & streak==STREAK_MAX), else IF if if_req & ~if_flush.
//   REQ: hold bus_req and fields. On bus_gnt: bus_req<=0, go to WAIT.
//   WAIT: on bus_rvalid, route the response to the owner combinationally in the same cycle, then go to IDLE.
//    Earliest next bus_req is 2 cycles after bus_rvalid.
//  Streak counter:
//   DM grant while if_req=1: streak+1, saturating at STREAK_MAX.
//   IF grant, or an IDLE cycle with if_req=0: streak<=0.
//  Flush:
//   if_flush while owner=IF in REQ or WAIT sets drop=1. The transaction still completes on the bus.
//   Its bus_rvalid is consumed with if_rvalid=0. drop clears on return to IDLE.
//   if_flush in the same cycle as bus_rvalid for IF: response discarded (flush wins).
//   if_flush while owner=DM: no effect on the DM transaction.
//  Other boundary rules:
//   bus_rvalid in IDLE or REQ is ignored; it is a stale response, e.g. after reset mid-transaction.
//   Reset mid-transaction: immediate return to IDLE with bus_req=0. The requester re-issues.
//   bus_gnt and bus_rvalid in the same cycle in REQ: accept gnt only; rvalid must come later.
//   bus_err on an IF response is forwarded as if_rvalid with bus_rdata unchanged (error handling is out of scope).
// STRUCTURE
//  Shared include mem_arb_defs.vh:
//   state encodings (IDLE/REQ/WAIT, 2 bits) and owner encodings (OWN_IF/OWN_DM).
//  Sub-module arb_pick:
//   combinational pick plus the streak counter register (inputs if_req, dm_req, if_flush, grant_evt; output grant_dm).
//  The FSM, bus regs and response routing stay in mem_port_arbiter.
// TESTING
//  1. Lone fetch, 0x100; gnt at cycle 2, rvalid at cycle 4 -> bus_req high cycles 1-2, if_rvalid=1 at cycle 4, dm_rvalid never.
//  2. if_req and dm_req together, STREAK_MAX=4, dm_req held across 5 transactions -> grant order DM,DM,DM,DM,IF,DM.
//  3. if_flush during WAIT of fetch 0x200 -> bus_rvalid consumed, if_rvalid stays 0. Next fetch 0x300 is granted normally.
//  4. rst=0 while in WAIT -> next cycle bus_req=0, state IDLE. A late bus_rvalid gives no if_rvalid or dm_rvalid.
//  5. Store dm_we=1, be=0b0011, wdata=0xDEADBEEF, addr=0x40 -> bus fields match, held stable 3 cycles until gnt; dm_rvalid on ack.
//  6. Load with bus_err=1 -> dm_rvalid=1, dm_err=1; dm_stall drops the same cycle.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and helpers for the instruction/data memory port arbiter.
package mem_port_arbiter_pkg;

  localparam int unsigned ARB_ADDR_W_DEF     = 32;
  localparam int unsigned ARB_DATA_W_DEF     = 32;
  localparam int unsigned ARB_STREAK_MAX_DEF = 4;

  // Transaction phase of the single outstanding bus access
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } arb_state_e;

  // Which port the outstanding transaction belongs to
  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_DM = 1'b1
  } arb_owner_e;

  // Width of a counter able to hold 0..max_val
  function automatic int unsigned streak_w(input int unsigned max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/mem_port_arbiter_pick.sv
// Grant selection between fetch and data ports plus the data-streak counter
// that forces a fetch grant after STREAK_MAX back-to-back data grants.
module mem_port_arbiter_pick
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned STREAK_MAX = ARB_STREAK_MAX_DEF
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic if_req_i,
  input  logic dm_req_i,
  input  logic if_flush_i,
  input  logic grant_evt_i,
  output logic grant_dm_c_o,
  output logic grant_if_c_o
);

  localparam int unsigned SW = streak_w(STREAK_MAX);

  logic [SW-1:0] streak_q;
  logic [SW-1:0] streak_d;
  logic          fetch_due_c;

  // Pick the winner and compute the next streak value on arbitration cycles
  always_comb begin
    fetch_due_c  = if_req_i && (streak_q == SW'(STREAK_MAX));
    grant_dm_c_o = dm_req_i && !fetch_due_c;
    grant_if_c_o = !grant_dm_c_o && if_req_i && !if_flush_i;
    streak_d     = streak_q;
    if (grant_evt_i) begin
      if (!if_req_i) begin
        streak_d = '0;
      end else if (grant_dm_c_o) begin
        streak_d = (streak_q == SW'(STREAK_MAX)) ? streak_q : streak_q + SW'(1);
      end else if (grant_if_c_o) begin
        streak_d = '0;
      end
    end
  end

  // Streak counter register
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      streak_q <= '0;
    end else begin
      streak_q <= streak_d;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory bus between the fetch and data ports of the core with a
// single outstanding transaction; routes responses back and drops responses
// of fetches that were flushed while in flight.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W     = ARB_ADDR_W_DEF,
  parameter int unsigned DATA_W     = ARB_DATA_W_DEF,
  parameter int unsigned STREAK_MAX = ARB_STREAK_MAX_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  input  logic                if_flush,
  output logic                if_rvalid,
  output logic [DATA_W-1:0]   if_rdata,
  output logic                if_stall,
  input  logic                dm_req,
  input  logic                dm_we,
  input  logic [DATA_W/8-1:0] dm_be,
  input  logic [ADDR_W-1:0]   dm_addr,
  input  logic [DATA_W-1:0]   dm_wdata,
  output logic                dm_rvalid,
  output logic [DATA_W-1:0]   dm_rdata,
  output logic                dm_err,
  output logic                dm_stall,
  output logic                bus_req,
  output logic                bus_we,
  output logic [DATA_W/8-1:0] bus_be,
  output logic [ADDR_W-1:0]   bus_addr,
  output logic [DATA_W-1:0]   bus_wdata,
  input  logic                bus_gnt,
  input  logic                bus_rvalid,
  input  logic [DATA_W-1:0]   bus_rdata,
  input  logic                bus_err
);

  localparam int unsigned BE_W = DATA_W / 8;

  arb_state_e          state_q,     state_d;
  arb_owner_e          owner_q,     owner_d;
  logic                drop_q,      drop_d;
  logic                bus_req_q,   bus_req_d;
  logic                bus_we_q,    bus_we_d;
  logic [BE_W-1:0]     bus_be_q,    bus_be_d;
  logic [ADDR_W-1:0]   bus_addr_q,  bus_addr_d;
  logic [DATA_W-1:0]   bus_wdata_q, bus_wdata_d;

  logic grant_dm_c;
  logic grant_if_c;
  logic resp_c;

  mem_port_arbiter_pick #(
    .STREAK_MAX (STREAK_MAX)
  ) u_pick (
    .clk_i        (clk),
    .rst_ni       (rst),
    .if_req_i     (if_req),
    .dm_req_i     (dm_req),
    .if_flush_i   (if_flush),
    .grant_evt_i  (state_q == ST_IDLE),
    .grant_dm_c_o (grant_dm_c),
    .grant_if_c_o (grant_if_c)
  );

  // Next-state logic: arbitrate in IDLE, hold request until grant, await response
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    drop_d      = drop_q;
    bus_req_d   = bus_req_q;
    bus_we_d    = bus_we_q;
    bus_be_d    = bus_be_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    unique case (state_q)
      ST_IDLE: begin
        drop_d = 1'b0;
        if (grant_dm_c) begin
          owner_d     = OWN_DM;
          bus_we_d    = dm_we;
          bus_be_d    = dm_be;
          bus_addr_d  = dm_addr;
          bus_wdata_d = dm_wdata;
          bus_req_d   = 1'b1;
          state_d     = ST_REQ;
        end else if (grant_if_c) begin
          owner_d     = OWN_IF;
          bus_we_d    = 1'b0;
          bus_be_d    = '1;
          bus_addr_d  = if_addr;
          bus_wdata_d = '0;
          bus_req_d   = 1'b1;
          state_d     = ST_REQ;
        end
      end
      ST_REQ: begin
        if ((owner_q == OWN_IF) && if_flush) begin
          drop_d = 1'b1;
        end
        // A response arriving alongside the grant is stale and ignored
        if (bus_gnt) begin
          bus_req_d = 1'b0;
          state_d   = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if ((owner_q == OWN_IF) && if_flush) begin
          drop_d = 1'b1;
        end
        if (bus_rvalid) begin
          drop_d  = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: begin
        bus_req_d = 1'b0;
        drop_d    = 1'b0;
        state_d   = ST_IDLE;
      end
    endcase
  end

  // State, ownership and bus command registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      owner_q     <= OWN_DM;
      drop_q      <= 1'b0;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_be_q    <= '0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      drop_q      <= drop_d;
      bus_req_q   <= bus_req_d;
      bus_we_q    <= bus_we_d;
      bus_be_q    <= bus_be_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
    end
  end

  // Same-cycle response routing; a flush in the response cycle discards a fetch
  always_comb begin
    resp_c    = (state_q == ST_WAIT) && bus_rvalid;
    if_rvalid = resp_c && (owner_q == OWN_IF) && !drop_q && !if_flush;
    dm_rvalid = resp_c && (owner_q == OWN_DM);
    if_rdata  = if_rvalid ? bus_rdata : '0;
    dm_rdata  = dm_rvalid ? bus_rdata : '0;
    dm_err    = dm_rvalid && bus_err;
    if_stall  = if_req && !if_rvalid;
    dm_stall  = dm_req && !dm_rvalid;
  end

  assign bus_req   = bus_req_q;
  assign bus_we    = bus_we_q;
  assign bus_be    = bus_be_q;
  assign bus_addr  = bus_addr_q;
  assign bus_wdata = bus_wdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a transaction-level reference model.
module tb_mem_port_arbiter;

  localparam int unsigned AW   = 32;
  localparam int unsigned DW   = 32;
  localparam int unsigned BW   = DW / 8;
  localparam int          SMAX = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          if_req, if_flush, if_rvalid, if_stall;
  logic [AW-1:0] if_addr;
  logic [DW-1:0] if_rdata;
  logic          dm_req, dm_we, dm_rvalid, dm_err, dm_stall;
  logic [BW-1:0] dm_be;
  logic [AW-1:0] dm_addr;
  logic [DW-1:0] dm_wdata, dm_rdata;
  logic          bus_req, bus_we, bus_gnt, bus_rvalid, bus_err;
  logic [BW-1:0] bus_be;
  logic [AW-1:0] bus_addr;
  logic [DW-1:0] bus_wdata, bus_rdata;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  mem_port_arbiter #(
    .ADDR_W     (AW),
    .DATA_W     (DW),
    .STREAK_MAX (SMAX)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .if_req     (if_req),
    .if_addr    (if_addr),
    .if_flush   (if_flush),
    .if_rvalid  (if_rvalid),
    .if_rdata   (if_rdata),
    .if_stall   (if_stall),
    .dm_req     (dm_req),
    .dm_we      (dm_we),
    .dm_be      (dm_be),
    .dm_addr    (dm_addr),
    .dm_wdata   (dm_wdata),
    .dm_rvalid  (dm_rvalid),
    .dm_rdata   (dm_rdata),
    .dm_err     (dm_err),
    .dm_stall   (dm_stall),
    .bus_req    (bus_req),
    .bus_we     (bus_we),
    .bus_be     (bus_be),
    .bus_addr   (bus_addr),
    .bus_wdata  (bus_wdata),
    .bus_gnt    (bus_gnt),
    .bus_rvalid (bus_rvalid),
    .bus_rdata  (bus_rdata),
    .bus_err    (bus_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h need 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0b need %0b (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model (transaction view) ----------------
  bit            m_on = 1'b0;
  bit            m_busy, m_acc, m_for_if, m_cancel;
  int            m_streak;
  logic          m_we;
  logic [BW-1:0] m_be;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;

  always @(posedge clk) begin
    if (!rst) begin
      m_on <= 1'b1; m_busy <= 1'b0; m_acc <= 1'b0; m_for_if <= 1'b0; m_cancel <= 1'b0;
      m_streak <= 0; m_we <= 1'b0; m_be <= '0; m_addr <= '0; m_wdata <= '0;
    end else if (!m_busy) begin
      m_cancel <= 1'b0;
      if (dm_req && !(if_req && m_streak >= SMAX)) begin
        m_busy <= 1'b1; m_acc <= 1'b0; m_for_if <= 1'b0;
        m_we <= dm_we; m_be <= dm_be; m_addr <= dm_addr; m_wdata <= dm_wdata;
        m_streak <= if_req ? ((m_streak + 1 > SMAX) ? SMAX : m_streak + 1) : 0;
      end else if (if_req && !if_flush) begin
        m_busy <= 1'b1; m_acc <= 1'b0; m_for_if <= 1'b1;
        m_we <= 1'b0; m_be <= '1; m_addr <= if_addr; m_wdata <= '0;
        m_streak <= 0;
      end else if (!if_req) begin
        m_streak <= 0;
      end
    end else if (!m_acc) begin
      if (bus_gnt) m_acc <= 1'b1;
      if (m_for_if && if_flush) m_cancel <= 1'b1;
    end else begin
      if (bus_rvalid) begin
        m_busy <= 1'b0;
        m_cancel <= 1'b0;
      end else if (m_for_if && if_flush) begin
        m_cancel <= 1'b1;
      end
    end
  end

  // Compare every cycle, away from the active edge
  always @(negedge clk) begin
    if (m_on) begin
      chk1 ("bus_req",   bus_req,   m_busy && !m_acc);
      chk1 ("bus_we",    bus_we,    m_we);
      chk32("bus_be",    32'(bus_be), 32'(m_be));
      chk32("bus_addr",  bus_addr,  m_addr);
      chk32("bus_wdata", bus_wdata, m_wdata);
      chk1 ("if_rvalid", if_rvalid, m_busy && m_acc && bus_rvalid && m_for_if && !m_cancel && !if_flush);
      chk32("if_rdata",  if_rdata,  (m_busy && m_acc && bus_rvalid && m_for_if && !m_cancel && !if_flush) ? bus_rdata : 32'h0);
      chk1 ("dm_rvalid", dm_rvalid, m_busy && m_acc && bus_rvalid && !m_for_if);
      chk32("dm_rdata",  dm_rdata,  (m_busy && m_acc && bus_rvalid && !m_for_if) ? bus_rdata : 32'h0);
      chk1 ("dm_err",    dm_err,    m_busy && m_acc && bus_rvalid && !m_for_if && bus_err);
      chk1 ("if_stall",  if_stall,  if_req && !(m_busy && m_acc && bus_rvalid && m_for_if && !m_cancel && !if_flush));
      chk1 ("dm_stall",  dm_stall,  dm_req && !(m_busy && m_acc && bus_rvalid && !m_for_if));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Acts as the bus slave for one transaction and reports what the ports saw
  task automatic do_bus(input int gnt_wait, input int rv_wait, input logic [31:0] rdata,
                        input logic err, input bit hold_dm, input bit stale_rv, input bit flush_at_rv,
                        output int first_req, output int nreq, output int rv_at,
                        output logic [31:0] got_addr, output logic saw_if, output logic saw_dm,
                        output logic [31:0] got_rdata, output logic got_err, output logic got_stall);
    int t0;
    int n;
    t0 = cyc; n = 0;
    first_req = -1; nreq = 0; rv_at = -1; got_addr = '0; saw_if = 1'b0; saw_dm = 1'b0;
    got_rdata = '0; got_err = 1'b0; got_stall = 1'b0;
    while (bus_req !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    chk1("bus_req_arrives", bus_req, 1'b1);
    if (bus_req !== 1'b1) return;
    first_req = cyc - t0;
    got_addr  = bus_addr;
    nreq      = 1;
    repeat (gnt_wait) begin
      step();
      if (bus_req === 1'b1) nreq++;
    end
    bus_gnt = 1'b1;
    if (stale_rv) begin
      bus_rvalid = 1'b1;
      bus_rdata  = 32'hBADBAD00;
    end
    step();
    bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = '0;
    repeat (rv_wait) step();
    bus_rvalid = 1'b1; bus_rdata = rdata; bus_err = err;
    if (flush_at_rv) if_flush = 1'b1;
    #1;
    rv_at     = cyc - t0;
    saw_if    = if_rvalid;
    saw_dm    = dm_rvalid;
    got_rdata = if_rvalid ? if_rdata : dm_rdata;
    got_err   = dm_err;
    got_stall = dm_req ? dm_stall : if_stall;
    step();
    bus_rvalid = 1'b0; bus_rdata = '0; bus_err = 1'b0; if_flush = 1'b0;
    if (saw_if || flush_at_rv) if_req = 1'b0;
    if (saw_dm && !hold_dm) dm_req = 1'b0;
  endtask

  // ---------------- directed tests ----------------
  initial begin
    int            fr, nr, ra;
    logic [31:0]   ga, gd;
    logic          si, sd, ge, gs;
    logic [31:0]   order [6];

    rst = 1'b0; if_req = 1'b0; if_addr = '0; if_flush = 1'b0;
    dm_req = 1'b0; dm_we = 1'b0; dm_be = '0; dm_addr = '0; dm_wdata = '0;
    bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = '0; bus_err = 1'b0;

    // Reset state; a response during reset must not leak out
    repeat (2) step();
    bus_rvalid = 1'b1; bus_rdata = 32'h12345678;
    #1;
    chk1 ("rst_bus_req",   bus_req,   1'b0);
    chk32("rst_bus_addr",  bus_addr,  32'h0);
    chk32("rst_bus_wdata", bus_wdata, 32'h0);
    chk1 ("rst_if_rvalid", if_rvalid, 1'b0);
    chk32("rst_if_rdata",  if_rdata,  32'h0);
    chk1 ("rst_dm_rvalid", dm_rvalid, 1'b0);
    chk32("rst_dm_rdata",  dm_rdata,  32'h0);
    step();
    bus_rvalid = 1'b0; bus_rdata = '0; rst = 1'b1;
    step();

    // 1. Lone fetch: bus_req in cycles 1-2, response in cycle 4
    if_req = 1'b1; if_addr = 32'h100;
    do_bus(1, 1, 32'h00000013, 1'b0, 1'b0, 1'b0, 1'b0, fr, nr, ra, ga, si, sd, gd, ge, gs);
    chk32("t1_first_req", 32'(fr), 32'd1);
    chk32("t1_req_cycles", 32'(nr), 32'd2);
    chk32("t1_rv_cycle",  32'(ra), 32'd4);
    chk32("t1_addr",      ga, 32'h100);
    chk1 ("t1_if_rvalid", si, 1'b1);
    chk1 ("t1_dm_rvalid", sd, 1'b0);
    chk32("t1_rdata",     gd, 32'h00000013);
    step();

    // 2. Data streak then forced fetch: DM,DM,DM,DM,IF,DM
    order[0] = 32'h80; order[1] = 32'h80; order[2] = 32'h80;
    order[3] = 32'h80; order[4] = 32'h500; order[5] = 32'h80;
    if_req = 1'b1; if_addr = 32'h500;
    dm_req = 1'b1; dm_we = 1'b0; dm_be = 4'hF; dm_addr = 32'h80; dm_wdata = '0;
    for (int k = 0; k < 6; k++) begin
      do_bus(0, 0, 32'h1000 + 32'(k), 1'b0, 1'b1, 1'b0, 1'b0, fr, nr, ra, ga, si, sd, gd, ge, gs);
      chk32("t2_grant_addr", ga, order[k]);
      chk1 ("t2_is_fetch",   si, k == 4);
      chk32("t2_rdata",      gd, 32'h1000 + 32'(k));
    end
    dm_req = 1'b0;
    step();

    // 3. Flush during WAIT drops the response; next fetch proceeds
    if_req = 1'b1; if_addr = 32'h200;
    step();
    chk32("t3_addr", bus_addr, 32'h200);
    bus_gnt = 1'b1;
    step();
    bus_gnt = 1'b0; if_flush = 1'b1; if_req = 1'b0;
    step();
    if_flush = 1'b0;
    step();
    bus_rvalid = 1'b1; bus_rdata = 32'h00000BAD;
    #1;
    chk1("t3_dropped_rvalid", if_rvalid, 1'b0);
    step();
    bus_rvalid = 1'b0; bus_rdata = '0;
    if_req = 1'b1; if_addr = 32'h300;
    do_bus(0, 1, 32'h33, 1'b0, 1'b0, 1'b0, 1'b0, fr, nr, ra, ga, si, sd, gd, ge, gs);
    chk32("t3_next_addr",   ga, 32'h300);
    chk1 ("t3_next_rvalid", si, 1'b1);
    chk32("t3_next_rdata",  gd, 32'h33);
    // Flush in the response cycle wins over the fetch response
    if_req = 1'b1; if_addr = 32'h340;
    do_bus(0, 0, 32'h34, 1'b0, 1'b0, 1'b0, 1'b1, fr, nr, ra, ga, si, sd, gd, ge, gs);
    chk1("t3_flush_wins", si, 1'b0);
    // Flush has no effect on a data transaction
    dm_req = 1'b1; dm_we = 1'b0; dm_be = 4'hF; dm_addr = 32'h88;
    do_bus(0, 1, 32'h88AA, 1'b0, 1'b0, 1'b0, 1'b1, fr, nr, ra, ga, si, sd, gd, ge, gs);
    chk1 ("t3_dm_unaffected", sd, 1'b1);
    chk32("t3_dm_rdata",      gd, 32'h88AA);
    step();

    // 4. Reset while waiting; a late response is ignored
    if_req = 1'b1; if_addr = 32'h400;
    step();
    bus_gnt = 1'b1;
    step();
    bus_gnt = 1'b0; rst = 1'b0; if_req = 1'b0;
    step();
    rst = 1'b1;
    chk1 ("t4_bus_req", bus_req, 1'b0);
    chk32("t4_bus_addr", bus_addr, 32'h0);
    step();
    bus_rvalid = 1'b1; bus_rdata = 32'h44;
    #1;
    chk1("t4_late_if", if_rvalid, 1'b0);
    chk1("t4_late_dm", dm_rvalid, 1'b0);
    step();
    bus_rvalid = 1'b0; bus_rdata = '0;
    step();

    // 5. Store: fields held for 3 cycles until grant, ack returns dm_rvalid
    dm_req = 1'b1; dm_we = 1'b1; dm_be = 4'b0011; dm_addr = 32'h40; dm_wdata = 32'hDEADBEEF;
    step();
    for (int i = 0; i < 3; i++) begin
      chk1 ("t5_req",   bus_req, 1'b1);
      chk1 ("t5_we",    bus_we,  1'b1);
      chk32("t5_be",    32'(bus_be), 32'h3);
      chk32("t5_addr",  bus_addr, 32'h40);
      chk32("t5_wdata", bus_wdata, 32'hDEADBEEF);
      if (i == 2) bus_gnt = 1'b1;
      step();
    end
    bus_gnt = 1'b0;
    chk1("t5_req_dropped", bus_req, 1'b0);
    step();
    bus_rvalid = 1'b1;
    #1;
    chk1("t5_ack",   dm_rvalid, 1'b1);
    chk1("t5_noerr", dm_err,    1'b0);
    step();
    bus_rvalid = 1'b0; dm_req = 1'b0; dm_we = 1'b0;
    step();

    // 6. Load with bus error; a response alongside the grant is ignored
    dm_req = 1'b1; dm_we = 1'b0; dm_be = 4'hF; dm_addr = 32'h44; dm_wdata = '0;
    do_bus(1, 2, 32'hCAFE0001, 1'b1, 1'b0, 1'b1, 1'b0, fr, nr, ra, ga, si, sd, gd, ge, gs);
    chk32("t6_addr",   ga, 32'h44);
    chk1 ("t6_rvalid", sd, 1'b1);
    chk1 ("t6_err",    ge, 1'b1);
    chk1 ("t6_stall",  gs, 1'b0);
    chk32("t6_rdata",  gd, 32'hCAFE0001);
    repeat (3) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Hard bound on run time
  initial begin
    #100000;
    $display("FAIL watchdog: got still running, need finished");
    $fatal(1, "watchdog expired");
  end

endmodule
